// File: rtl/ov_dvp_pkg.sv
// Shared DVP definitions: FSM state encoding, default VGA timing and the RGB565 payload.
// Also used by the capture side's testbench.
package ov_dvp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_H_BLANK     = 144;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_VSYNC_LINES = 3;
  localparam int unsigned DEF_V_BACK      = 17;
  localparam int unsigned DEF_V_FRONT     = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ov_dvp_tx_if.sv
// RGB565 pixel stream (valid/ready) feeding the DVP transmitter.
interface ov_dvp_tx_if;
  import ov_dvp_pkg::*;

  rgb565_t s_data;
  logic    s_valid;
  logic    s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ov_dvp_timing.sv
// Line/frame sequencer: hcnt runs over every line, vcnt counts lines within the current state.
module ov_dvp_timing
  import ov_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned HW          = 11,
  parameter int unsigned VW          = 9
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [2:0]    state,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt
);

  localparam int unsigned L = 2 * H_ACTIVE + H_BLANK;

  logic [2:0]    state_nxt;
  logic [HW-1:0] hcnt_nxt;
  logic [VW-1:0] vcnt_nxt;
  logic [VW-1:0] vlast_c;
  logic          wrap_c;

  assign wrap_c = (hcnt == HW'(L - 1));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
    end
  end

  // State only moves on the wrap of its last line; enable matters only in IDLE and at frame end.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    vlast_c   = '0;
    case (state)
      ST_VSYNC:  vlast_c = VW'(VSYNC_LINES - 1);
      ST_VBACK:  vlast_c = VW'(V_BACK - 1);
      ST_ACTIVE: vlast_c = VW'(V_ACTIVE - 1);
      ST_VFRONT: vlast_c = VW'(V_FRONT - 1);
      default:   vlast_c = '0;
    endcase
    if (state == ST_IDLE) begin
      hcnt_nxt = '0;
      vcnt_nxt = '0;
      if (enable) state_nxt = ST_VSYNC;
    end else if (wrap_c) begin
      hcnt_nxt = '0;
      if (vcnt == vlast_c) begin
        vcnt_nxt = '0;
        case (state)
          ST_VSYNC:  state_nxt = ST_VBACK;
          ST_VBACK:  state_nxt = ST_ACTIVE;
          ST_ACTIVE: state_nxt = ST_VFRONT;
          ST_VFRONT: state_nxt = enable ? ST_VSYNC : ST_IDLE;
          default:   state_nxt = ST_IDLE;
        endcase
      end else begin
        vcnt_nxt = vcnt + VW'(1);
      end
    end else begin
      hcnt_nxt = hcnt + HW'(1);
    end
  end

endmodule

// File: rtl/ov_dvp_tx.sv
// Camera-side DVP transmitter: RGB565 stream in, vsync/href/byte bus out, high byte first.
// One-pixel holding buffer prefetches across blanking; starved pixels go out as zeros.
module ov_dvp_tx
  import ov_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned V_FRONT     = DEF_V_FRONT
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  ov_dvp_tx_if.slave  bus,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d_out,
  output logic        frame_start,
  output logic        underflow
);

  localparam int unsigned L    = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned VM01 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned VM23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned VMAX = (VM01 > VM23) ? VM01 : VM23;
  localparam int unsigned HW   = cnt_w(L);
  localparam int unsigned VW   = cnt_w(VMAX);

  logic [2:0]    state;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  rgb565_t    pbuf_q;
  logic       pfull_q;
  logic [7:0] lo_q;
  logic       run_q;

  logic active_c, consume_c, accept_c, starve_c, fs_c;

  ov_dvp_timing #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .HW(HW), .VW(VW)
  ) u_timing (
    .pclk    (pclk),
    .reset_n (reset_n),
    .enable  (enable),
    .state   (state),
    .hcnt    (hcnt),
    .vcnt    (vcnt)
  );

  assign active_c  = (state == ST_ACTIVE) && (hcnt < HW'(2 * H_ACTIVE));
  assign consume_c = active_c && !hcnt[0];
  assign starve_c  = consume_c && !pfull_q;
  assign fs_c      = (state == ST_VSYNC) && (hcnt == '0) && (vcnt == '0);
  // run_q keeps s_ready low until the first edge after reset release.
  assign bus.s_ready = run_q && (!pfull_q || consume_c);
  assign accept_c    = bus.s_valid && bus.s_ready;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      pbuf_q      <= '0;
      pfull_q     <= 1'b0;
      lo_q        <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d_out       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      // Consume reads the old pixel; a same-cycle accept refills the buffer.
      if (accept_c) begin
        pbuf_q  <= bus.s_data;
        pfull_q <= 1'b1;
      end else if (consume_c) begin
        pfull_q <= 1'b0;
      end
      if (consume_c) begin
        d_out <= pfull_q ? pbuf_q[15:8] : 8'h00;
        lo_q  <= pfull_q ? pbuf_q[7:0]  : 8'h00;
      end else if (active_c) begin
        d_out <= lo_q;
      end else begin
        d_out <= 8'h00;
      end
      vsync       <= (state == ST_VSYNC);
      href        <= active_c;
      frame_start <= fs_c;
      underflow   <= (underflow && !fs_c) || starve_c;
    end
  end

endmodule
